// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: display mode and control state encodings.
// Also holds the concentric-ring distance helper used by the pattern logic.
package led_pkg;

    typedef enum logic [1:0] {
        RINGS     = 2'd0,
        CHECKER   = 2'd1,
        ROW_SWEEP = 2'd2,
        COL_SWEEP = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // Distance of a pixel from the nearest array edge, i.e. its ring number.
    function automatic int ring_dist(input int r, input int c, input int rows, input int cols);
        int d;
        d = r;
        if (c < d)
            d = c;
        if (rows - 1 - r < d)
            d = rows - 1 - r;
        if (cols - 1 - c < d)
            d = cols - 1 - c;
        return d;
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Animation prescaler: counts 0..TICK_DIV-1 while enabled, tick is combinational on the last count.
// Holds its count when disabled; clr zeroes it with priority over en. No backpressure.
module led_tick_div #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED matrix animator (OFF/RUN/PAUSE); pixels are registered one cycle after (mode_q, phase) change.
// No backpressure; optional LED_PATTERN_STEP_EN adds step_req for single-stepping while paused.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int TICK_DIV = 12500000
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       stop,
    input  logic [1:0]                 mode,
`ifdef LED_PATTERN_STEP_EN
    input  logic                       step_req,
`endif
    output logic [ROWS-1:0][COLS-1:0]  RedPixels,
    output logic [ROWS-1:0][COLS-1:0]  GrnPixels,
    output logic                       frame_done
);

    localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;
    localparam int PW   = $clog2(MAXD);
    localparam int AW   = $clog2(ROWS + COLS + MAXD) + 1;

    state_e                     state_q, state_d;
    mode_e                      mode_q;
    logic [PW-1:0]              phase;
    logic                       prescale_tick;
    logic                       step;
    logic [AW-1:0]              row_sel, col_sel, sum;
    logic [ROWS-1:0][COLS-1:0]  red_d, grn_d;

    led_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk  (clk),
        .RST  (RST),
        .en   (state_q == RUN),
        .clr  (state_q == OFF),
        .tick (prescale_tick)
    );

`ifdef LED_PATTERN_STEP_EN
    assign step = prescale_tick || ((state_q == PAUSE) && step_req);
`else
    assign step = prescale_tick;
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            state_q <= OFF;
        else
            state_q <= state_d;
    end

    // stop outranks pause, pause outranks start
    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     if (!stop && start) state_d = RUN;
            RUN:     if (stop) state_d = OFF;
                     else if (pause) state_d = PAUSE;
            PAUSE:   if (stop) state_d = OFF;
                     else if (start && !pause) state_d = RUN;
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            phase      <= '0;
            mode_q     <= RINGS;
            frame_done <= 1'b0;
        end else begin
            frame_done <= step && (phase == PW'(MAXD - 1));
            if (state_q == OFF)
                phase <= '0;
            else if (step)
                phase <= (phase == PW'(MAXD - 1)) ? '0 : phase + 1'b1;
            if (((state_q == OFF) && (state_d == RUN)) || step)
                mode_q <= mode_e'(mode);
        end
    end

    always_comb begin
        red_d   = '0;
        grn_d   = '0;
        sum     = '0;
        row_sel = AW'(phase) % AW'(ROWS);
        col_sel = AW'(phase) % AW'(COLS);
        if (state_q != OFF) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    case (mode_q)
                        RINGS: begin
                            sum         = AW'(ring_dist(r, c, ROWS, COLS)) + AW'(phase);
                            red_d[r][c] = ~sum[0];
                            grn_d[r][c] = sum[0];
                        end
                        CHECKER: begin
                            sum         = AW'(r) + AW'(c) + AW'(phase);
                            red_d[r][c] = ~sum[0];
                            grn_d[r][c] = sum[0];
                        end
                        ROW_SWEEP: red_d[r][c] = (AW'(r) == row_sel);
                        COL_SWEEP: grn_d[r][c] = (AW'(c) == col_sel);
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            RedPixels <= '0;
            GrnPixels <= '0;
        end else begin
            RedPixels <= red_d;
            GrnPixels <= grn_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at 16x16, TICK_DIV=4; expected pixel rows are hand-derived.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_led_pattern_gen;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int TD   = 4;

    logic                      clk = 1'b0;
    logic                      RST;
    logic                      start, pause, stop;
    logic [1:0]                mode;
`ifdef LED_PATTERN_STEP_EN
    logic                      step_req;
`endif
    logic [ROWS-1:0][COLS-1:0] red, grn;
    logic                      frame_done;

    int n_chk  = 0;
    int n_pass = 0;
    int fd_cnt = 0;
    int fd_at  = -1;

    always #5 clk = ~clk;

    led_pattern_gen #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .RST        (RST),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .mode       (mode),
`ifdef LED_PATTERN_STEP_EN
        .step_req   (step_req),
`endif
        .RedPixels  (red),
        .GrnPixels  (grn),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [255:0] row_only(input int p);
        logic [ROWS-1:0][COLS-1:0] e;
        e    = '0;
        e[p] = '1;
        return e;
    endfunction

    function automatic logic [255:0] col_only(input int p);
        logic [ROWS-1:0][COLS-1:0] e;
        e = '0;
        for (int r = 0; r < ROWS; r++)
            e[r][p] = 1'b1;
        return e;
    endfunction

    initial begin
        RST   = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        mode  = 2'd0;
`ifdef LED_PATTERN_STEP_EN
        step_req = 1'b0;
`endif
        cyc(2);
        chk("reset_red", red, '0);
        chk("reset_grn", grn, '0);
        chk("reset_frame_done", 256'(frame_done), 256'(0));
        RST = 1'b0;
        cyc(1);

        // RINGS: run entered at E0, phase 0 visible at E1, phase 1 visible at E5
        start = 1'b1;
        mode  = 2'd0;
        cyc(2);
        chk("rings_red0", 256'(red[0]), 256'(16'hFFFF));
        chk("rings_red1", 256'(red[1]), 256'(16'h8001));
        chk("rings_grn1", 256'(grn[1]), 256'(16'h7FFE));
        chk("rings_red15", 256'(red[15]), 256'(16'hFFFF));
        cyc(3);
        chk("rings_hold_red0", 256'(red[0]), 256'(16'hFFFF));
        cyc(1);
        chk("rings_step_red0", 256'(red[0]), 256'(16'h0000));
        chk("rings_step_grn0", 256'(grn[0]), 256'(16'hFFFF));
        chk("rings_step_red1", 256'(red[1]), 256'(16'h7FFE));

        // asynchronous reset mid-run, then idle without start
        RST = 1'b1;
        #1;
        chk("rst_async_red", red, '0);
        chk("rst_async_grn", grn, '0);
        cyc(1);
        start = 1'b0;
        RST   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("rst_idle", red | grn, '0);
        end

        // ROW_SWEEP across a full frame
        mode  = 2'd2;
        start = 1'b1;
        cyc(1);
        for (int k = 1; k <= 68; k++) begin
            cyc(1);
            if (frame_done) begin
                fd_cnt++;
                fd_at = k;
            end
            if (k % 4 == 1) begin
                chk("row_sweep_red", red, row_only(((k - 1) / 4) % 16));
                chk("row_sweep_grn", grn, '0);
            end
        end
        chk("frame_done_count", 256'(fd_cnt), 256'(1));
        chk("frame_done_cycle", 256'(fd_at), 256'(64));

        // stop wins over pause and start
        pause = 1'b1;
        stop  = 1'b1;
        cyc(2);
        chk("prio_stop_off", red | grn, '0);

        // pause wins over start; prescaler and phase hold while paused
        stop  = 1'b0;
        pause = 1'b0;
        cyc(1);
        pause = 1'b1;
        cyc(13);
        chk("pause_frozen", red, row_only(0));
        pause = 1'b0;
        cyc(4);
        chk("resume_hold", red, row_only(0));
        cyc(1);
        chk("resume_step", red, row_only(1));

        // mode change between steps is ignored until the next step
        stop = 1'b1;
        cyc(2);
        stop = 1'b0;
        mode = 2'd1;
        cyc(2);
        mode = 2'd3;
        chk("checker_red0", 256'(red[0]), 256'(16'h5555));
        chk("checker_grn0", 256'(grn[0]), 256'(16'hAAAA));
        chk("checker_red1", 256'(red[1]), 256'(16'hAAAA));
        cyc(3);
        chk("latch_hold_red0", 256'(red[0]), 256'(16'h5555));
        chk("latch_hold_grn0", 256'(grn[0]), 256'(16'hAAAA));
        cyc(1);
        chk("col_sweep_grn", grn, col_only(1));
        chk("col_sweep_red", red, '0);

`ifdef LED_PATTERN_STEP_EN
        // single step while paused at phase 5
        cyc(16);
        chk("step_pre_col5", grn, col_only(5));
        pause = 1'b1;
        cyc(2);
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0;
        chk("step_hold_col5", grn, col_only(5));
        cyc(1);
        chk("step_adv_col6", grn, col_only(6));
        pause = 1'b0;
        cyc(3);
        chk("step_presc_col6", grn, col_only(6));
        cyc(1);
        chk("step_presc_col7", grn, col_only(7));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of LED rows.
REQ-002 SHALL have parameter COLS, default 16, number of LED columns.
REQ-003 SHALL have parameter TICK_DIV, default 12500000, clk cycles per animation step (>=2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  level; enter/resume RUN.
REQ-007 SHALL have port pause  input  1  level; freeze animation.
REQ-008 SHALL have port stop  input  1  level; blank display, return to OFF.
REQ-009 SHALL have port mode  input  2  pattern select: 0 RINGS, 1 CHECKER, 2 ROW_SWEEP, 3 COL_SWEEP.
REQ-010 SHALL have port RedPixels  output  [ROWS-1:0][COLS-1:0]  registered red LED array.
REQ-011 SHALL have port GrnPixels  output  [ROWS-1:0][COLS-1:0]  registered green LED array.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when phase wraps.

Function
REQ-013 SHALL implement FSM states OFF, RUN, PAUSE; input priority stop > pause > start.
REQ-014 Transitions SHALL be: OFF->RUN on start; RUN->PAUSE on pause; PAUSE->RUN on start with pause low; any->OFF on stop.
REQ-015 In RUN, prescaler SHALL count 0..TICK_DIV-1; at TICK_DIV-1 it SHALL assert internal step and wrap to 0.
REQ-016 In PAUSE prescaler and phase SHALL hold; in OFF both SHALL clear to 0.
REQ-017 phase SHALL be $clog2(MAXD) bits, MAXD = max(ROWS,COLS), incrementing on step and wrapping MAXD-1 -> 0.
REQ-018 frame_done SHALL pulse for exactly the cycle after a step that wraps phase to 0.
REQ-019 mode SHALL be latched into mode_q on OFF->RUN and on every step; mode changes between steps SHALL NOT affect the display.
REQ-020 Ring index d(r,c) SHALL equal min(r, c, ROWS-1-r, COLS-1-c).
REQ-021 RINGS: Red[r][c] = (d+phase) even; Grn = ~Red.
REQ-022 CHECKER: Red[r][c] = (r+c+phase) even; Grn = ~Red.
REQ-023 ROW_SWEEP: Red row (phase mod ROWS) all ones, other rows zero; Grn all zero.
REQ-024 COL_SWEEP: Grn column (phase mod COLS) all ones, others zero; Red all zero.
REQ-025 Pixel registers SHALL reflect (mode_q, phase) one cycle after either changes; in OFF both arrays SHALL be all zero one cycle after entry.
REQ-026 Pattern arithmetic SHALL use widths wide enough to avoid overflow at ROWS+COLS+MAXD.

Reset
REQ-027 RST high SHALL immediately force state OFF, prescaler 0, phase 0, mode_q RINGS, RedPixels '0, GrnPixels '0, frame_done 0.
REQ-028 RST asserted mid-RUN SHALL abort the animation; after release the block SHALL remain in OFF until start.

Configuration
REQ-029 With macro LED_PATTERN_STEP_EN defined, SHALL add input step_req (1 bit); a step_req pulse in PAUSE SHALL advance phase by one exactly as a prescaler step (mode latch and frame_done included).
REQ-030 Without LED_PATTERN_STEP_EN, step_req SHALL NOT exist and PAUSE SHALL be fully frozen.

Structure
REQ-031 Package led_pkg SHALL hold the mode enum (RINGS, CHECKER, ROW_SWEEP, COL_SWEEP) and state enum (OFF, RUN, PAUSE).
REQ-032 Prescaler SHALL be a sub-module led_tick_div (parameter TICK_DIV; ports clk, RST, en, clr, tick).

Verification (ROWS=COLS=16, TICK_DIV=4)
REQ-033 Reset: RST=1 during RUN -> both arrays 0 same cycle; after release start=0 keeps arrays 0 for 20 cycles.
REQ-034 RINGS: start=1, mode=0 -> Red[0]=16'hFFFF, Red[1]=16'h8001, Grn[1]=16'h7FFE; after 4 cycles step -> Red[0]=16'h0000.
REQ-035 ROW_SWEEP: mode=2, run 64 cycles -> Red row 0..15 lit in turn one per 4 cycles; frame_done pulses once after phase 15->0.
REQ-036 Priority: start=pause=stop=1 in RUN -> OFF next cycle, arrays 0; pause+start with stop=0 -> PAUSE.
REQ-037 Mode latch: mode 1->3 mid-step (prescaler=1) -> CHECKER held until next step, then COL_SWEEP column phase lit in Grn.
REQ-038 With LED_PATTERN_STEP_EN: PAUSE at phase 5, step_req pulse -> phase 6, display updates next cycle, prescaler unchanged.
